// File: rtl/float_multiplier_seq.sv
// Multi-cycle floating-point multiplier.
// The significands are multiplied by shift-add, one partial product per clock.
// The product is then normalised and truncated in a single cycle.
// Results are held behind a valid/ready handshake.
module float_multiplier_seq #(
    parameter int FLOAT_SIZE    = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int BIAS          = 127
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLOAT_SIZE-1:0] a,
    input  logic [FLOAT_SIZE-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLOAT_SIZE-1:0] out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact
);

    localparam int SIG_W  = MANTISSA_SIZE + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EXP_W  = EXPONENT_SIZE + 2;
    localparam int CNT_W  = $clog2(SIG_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [SIG_W-1:0]         sig_a_r;
    logic [SIG_W-1:0]         sig_b_r;
    logic [EXPONENT_SIZE-1:0] exp_a_r;
    logic [EXPONENT_SIZE-1:0] exp_b_r;
    logic                     sign_r;
    logic [PROD_W-1:0]        acc_r;
    logic [CNT_W-1:0]         cnt_r;

    logic [PROD_W-1:0]        pp_s;
    logic [MANTISSA_SIZE-1:0] mant_s;
    logic                     inexact_s;
    logic [EXP_W-1:0]         exp_sum_s;

    logic                     in_ready_r;
    logic                     out_valid_r;
    logic [FLOAT_SIZE-1:0]    out_r;
    logic                     overflow_r;
    logic                     underflow_r;
    logic                     inexact_r;

    // Biased exponent sum with two guard bits.
    // The top bit flags a negative (underflowed) result.
    // The next bit flags overflow past the field width.
    function automatic logic [EXP_W-1:0] exp_calc(
        input logic [EXPONENT_SIZE-1:0] ea,
        input logic [EXPONENT_SIZE-1:0] eb,
        input logic                     norm
    );
        return {2'b00, ea} + {2'b00, eb} + {{(EXP_W-1){1'b0}}, norm} - EXP_W'(BIAS);
    endfunction

    // Next-state decode for the IDLE/MULT/NORM/DONE sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_next_s = MULT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MULT: begin
                if (cnt_r == CNT_W'(MANTISSA_SIZE)) begin
                    state_next_s = NORM;
                end else begin
                    state_next_s = MULT;
                end
            end
            NORM: state_next_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Partial product for the current multiplier bit
    always_comb begin
        pp_s = {PROD_W{1'b0}};
        if (sig_b_r[cnt_r]) begin
            pp_s = {{SIG_W{1'b0}}, sig_a_r} << cnt_r;
        end else begin
            pp_s = {PROD_W{1'b0}};
        end
    end

    // Normalise a product in [1,4): drop the hidden bit and truncate the rest
    always_comb begin
        mant_s    = {MANTISSA_SIZE{1'b0}};
        inexact_s = 1'b0;
        if (acc_r[PROD_W-1]) begin
            mant_s    = acc_r[PROD_W-2 -: MANTISSA_SIZE];
            inexact_s = |acc_r[PROD_W-MANTISSA_SIZE-2:0];
        end else begin
            mant_s    = acc_r[PROD_W-3 -: MANTISSA_SIZE];
            inexact_s = |acc_r[PROD_W-MANTISSA_SIZE-3:0];
        end
        exp_sum_s = exp_calc(exp_a_r, exp_b_r, acc_r[PROD_W-1]);
    end

    // State register, operand capture and shift-add accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            sig_a_r <= {SIG_W{1'b0}};
            sig_b_r <= {SIG_W{1'b0}};
            exp_a_r <= {EXPONENT_SIZE{1'b0}};
            exp_b_r <= {EXPONENT_SIZE{1'b0}};
            sign_r  <= 1'b0;
            acc_r   <= {PROD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        sig_a_r <= {1'b1, a[MANTISSA_SIZE-1:0]};
                        sig_b_r <= {1'b1, b[MANTISSA_SIZE-1:0]};
                        exp_a_r <= a[FLOAT_SIZE-2 -: EXPONENT_SIZE];
                        exp_b_r <= b[FLOAT_SIZE-2 -: EXPONENT_SIZE];
                        sign_r  <= a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
                        acc_r   <= {PROD_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                MULT: begin
                    acc_r <= acc_r + pp_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake and result outputs.
    // The result is loaded only when leaving NORM.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= {FLOAT_SIZE{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            inexact_r   <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            if (state_r == NORM) begin
                out_r       <= {sign_r, exp_sum_s[EXPONENT_SIZE-1:0], mant_s};
                underflow_r <= exp_sum_s[EXP_W-1];
                overflow_r  <= exp_sum_s[EXP_W-2] & ~exp_sum_s[EXP_W-1];
                inexact_r   <= inexact_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign inexact   = inexact_r;

endmodule

// File: tb/tb_float_multiplier_seq.sv
// Self-checking bench for float_multiplier_seq.
// It applies directed and random operands and compares the results with an
// arithmetic reference model.
module tb_float_multiplier_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    float_multiplier_seq #(
        .FLOAT_SIZE(32),
        .EXPONENT_SIZE(8),
        .MANTISSA_SIZE(23),
        .BIAS(127)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .overflow(overflow),
        .underflow(underflow),
        .inexact(inexact)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product of the significands with truncation.
    // The exponent is computed as a signed integer.
    // Returns {ovf, unf, inexact, result[31:0]}.
    function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx;
        logic [63:0] sy;
        logic [63:0] p;
        logic        n;
        logic        inx;
        logic [22:0] m;
        int          e;
        sx = 64'h0000_0000_0080_0000 | {41'd0, x[22:0]};
        sy = 64'h0000_0000_0080_0000 | {41'd0, y[22:0]};
        p  = sx * sy;
        n  = (p >= 64'h0000_8000_0000_0000);
        if (n) begin
            m   = 23'(p >> 24);
            inx = (p & 64'h0000_0000_00FF_FFFF) != 64'd0;
        end else begin
            m   = 23'(p >> 23);
            inx = (p & 64'h0000_0000_007F_FFFF) != 64'd0;
        end
        e = int'(x[30:23]) + int'(y[30:23]) + (n ? 1 : 0) - 127;
        return {(e >= 256), (e < 0), inx, x[31] ^ y[31], 8'(e), m};
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int hold,
                          input logic use_exp, input logic [31:0] exp_out, input string tag);
        logic [34:0] r;
        int          k;
        r = ref_mul(x, y);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        k        = 0;
        while (!out_valid && k < 60) begin
            @(posedge clk); #1;
            k++;
            if (k < 24) begin
                a = $urandom;
                b = $urandom;
            end
            if (!out_valid) begin
                if (in_ready) begin
                    check({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
                end
            end
        end
        check({tag, "_latency"}, 64'(k), 64'd25);
        if (use_exp) check({tag, "_out_spec"}, 64'(out), 64'(exp_out));
        check({tag, "_out"}, 64'(out), 64'(r[31:0]));
        check({tag, "_flags"}, {61'd0, overflow, underflow, inexact}, {61'd0, r[34:32]});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {out_valid, in_ready, overflow, underflow, inexact, out},
                  {1'b1, 1'b0, r[34:32], r[31:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
        check({tag, "_kept"}, 64'(out), 64'(r[31:0]));
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {in_ready, out_valid, overflow, underflow, inexact, out}, {5'b10000, 32'd0});
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(32'h3FC00000, 32'h40000000, 0,  1'b1, 32'h40400000, "basic");
        run_op(32'h3FC00000, 32'h3FC00000, 0,  1'b1, 32'h40100000, "norm");
        run_op(32'hC0000000, 32'h40400000, 0,  1'b1, 32'hC0C00000, "sign");
        run_op(32'h3F800001, 32'h3F800001, 0,  1'b1, 32'h3F800002, "inexact");
        check("inexact_flag", {61'd0, overflow, underflow, inexact}, 64'd1);
        run_op(32'h7F000000, 32'h7F000000, 10, 1'b1, 32'h3E800000, "overflow");
        check("overflow_flag", {61'd0, overflow, underflow, inexact}, 64'd4);
        run_op(32'h00800000, 32'h00800000, 0,  1'b1, 32'h41800000, "underflow");
        check("underflow_flag", {61'd0, overflow, underflow, inexact}, 64'd2);

        // Reset in the middle of MULT
        in_valid = 1'b1;
        a        = 32'h40490FDB;
        b        = 32'h402DF854;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_state", {in_ready, out_valid, overflow, underflow, inexact, out}, {5'b10000, 32'd0});
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) check("midreset_no_valid", 64'(out_valid), 64'd0);
        end
        run_op(32'h3FC00000, 32'h40000000, 2, 1'b1, 32'h40400000, "after_reset");

        for (int t = 0; t < 30; t++) begin
            rx = $urandom;
            ry = $urandom;
            run_op(rx, ry, int'($urandom_range(0, 3)), 1'b0, 32'd0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
